// File: rtl/mul_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_share_ctrl                                                  |
// | Purpose  : Round-robin sequencer sharing one fixed-latency multiplier      |
// |            between two requesters; optional MUL_ZERO_BYPASS_EN macro       |
// |            short-circuits zero operands.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mul_share_ctrl #(
    parameter int SIZE        = 8,
    parameter int MUL_LATENCY = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [SIZE-1:0]     a0,
    input  logic [SIZE-1:0]     b0,
    input  logic                req1,
    input  logic [SIZE-1:0]     a1,
    input  logic [SIZE-1:0]     b1,
    output logic                ack0,
    output logic                ack1,
    output logic                done0,
    output logic                done1,
    output logic [2*SIZE-1:0]   result,
    output logic                busy,
    output logic                mul_load,
    output logic [SIZE-1:0]     mul_a,
    output logic [SIZE-1:0]     mul_b,
    input  logic [2*SIZE-1:0]   mul_result
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;
    localparam logic [7:0] c_LAST = 8'(MUL_LATENCY - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_last_grant;
    logic [7:0]      r_cnt;
    logic            w_accept;
    logic            w_pick1;
    logic            w_bypass;
    logic            w_owner_d;
    logic [SIZE-1:0] w_win_a;
    logic [SIZE-1:0] w_win_b;
    logic            w_ack0_d;
    logic            w_ack1_d;
    logic            w_done0_d;
    logic            w_done1_d;
    logic            w_busy_d;
    logic            w_load_d;

    // Ties go to whichever requester was not served last.
    always_comb begin
        w_accept = (r_state == c_IDLE) && (req0 || req1);
        w_pick1  = req1 && (!req0 || !r_last_grant);
        w_win_a  = w_pick1 ? a1 : a0;
        w_win_b  = w_pick1 ? b1 : b0;
    end

`ifdef MUL_ZERO_BYPASS_EN
    assign w_bypass = (w_win_a == '0) || (w_win_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_bypass ? c_DONE : c_LOAD;
                end
            end
            c_LOAD: w_next_state = c_WAIT;
            c_WAIT: begin
                if (r_cnt == c_LAST) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered on the same edge.
    always_comb begin
        w_owner_d = w_accept ? w_pick1 : r_last_grant;
        w_ack0_d  = w_accept && !w_pick1;
        w_ack1_d  = w_accept && w_pick1;
        w_load_d  = (w_next_state == c_LOAD);
        w_done0_d = (w_next_state == c_DONE) && !w_owner_d;
        w_done1_d = (w_next_state == c_DONE) && w_owner_d;
        w_busy_d  = (w_next_state != c_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            busy         <= 1'b0;
            mul_load     <= 1'b0;
            result       <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            r_last_grant <= 1'b1;
            r_cnt        <= 8'd0;
        end else begin
            ack0     <= w_ack0_d;
            ack1     <= w_ack1_d;
            done0    <= w_done0_d;
            done1    <= w_done1_d;
            busy     <= w_busy_d;
            mul_load <= w_load_d;
            if (w_accept) begin
                r_last_grant <= w_pick1;
                if (!w_bypass) begin
                    mul_a <= w_win_a;
                    mul_b <= w_win_b;
                end
            end
            if (r_state == c_LOAD) begin
                r_cnt <= 8'd0;
            end else if (r_state == c_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Entering DONE from IDLE only happens on a zero bypass.
            if (w_next_state == c_DONE) begin
                result <= (r_state == c_WAIT) ? mul_result : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mul_share_ctrl                                               |
// | Purpose  : Directed self-checking bench for mul_share_ctrl (SIZE=8, L=8).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mul_share_ctrl;

    localparam int SIZE = 8;
    localparam int L    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [SIZE-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic            ack0, ack1, done0, done1, busy, mul_load;
    logic [15:0]     result;
    logic [SIZE-1:0] mul_a, mul_b;
    logic [15:0]     mul_result = 16'h0;

    int n_cmp = 0;
    int n_err = 0;

    mul_share_ctrl #(.SIZE(SIZE), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: product appears exactly L edges after the load edge, junk before.
    logic [15:0] m_pend = 16'h0;
    int          m_cnt  = 0;
    always @(posedge clk) begin
        if (mul_load) begin
            m_pend     <= 16'(mul_a) * 16'(mul_b);
            m_cnt      <= L - 1;
            mul_result <= (L == 1) ? 16'(mul_a) * 16'(mul_b) : 16'hDEAD;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) mul_result <= m_pend;
        end
    end

    // Raises one request at a negedge (controller idle) and records what happens.
    task automatic run_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                          output int k_ack, output bit ack_who, output int k_done,
                          output bit done_who, output logic [15:0] res,
                          output int n_load, output int n_busy);
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; end
        k_ack = -1; k_done = -1; ack_who = 1'b0; done_who = 1'b0;
        res = 16'hxxxx; n_load = 0; n_busy = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (mul_load) n_load++;
            if ((ack0 || ack1) && k_ack < 0) begin
                k_ack = k; ack_who = ack1;
                if (who) req1 = 1'b0; else req0 = 1'b0;
            end
            if (done0 || done1) begin
                k_done = k; done_who = done1; res = result;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({ack0, ack1, done0, done1, busy, mul_load} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 000000", {ack0, ack1, done0, done1, busy, mul_load}); end
        n_cmp++; if ({result, mul_a, mul_b} !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got %h required 0", {result, mul_a, mul_b}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int k_ack, k_done, n_load, n_busy; bit aw, dw; logic [15:0] res;
        run_op(1'b0, 8'd12, 8'd11, k_ack, aw, k_done, dw, res, n_load, n_busy);
        n_cmp++; if (k_ack !== 1 || aw !== 1'b0) begin
            n_err++; $display("FAIL basic_ack: got k=%0d who=%0d required k=1 who=0", k_ack, aw); end
        n_cmp++; if (n_load !== 1) begin
            n_err++; $display("FAIL basic_load: got %0d pulses required 1", n_load); end
        n_cmp++; if (k_done !== 10 || dw !== 1'b0) begin
            n_err++; $display("FAIL basic_done: got k=%0d who=%0d required k=10 who=0", k_done, dw); end
        n_cmp++; if (res !== 16'h0084) begin
            n_err++; $display("FAIL basic_result: got %h required 0084", res); end
        n_cmp++; if (n_busy !== 10) begin
            n_err++; $display("FAIL basic_busy: got %0d cycles required 10", n_busy); end
        n_cmp++; if (mul_a !== 8'd12 || mul_b !== 8'd11) begin
            n_err++; $display("FAIL basic_operands: got %0d,%0d required 12,11", mul_a, mul_b); end
        @(negedge clk);
        n_cmp++; if ({busy, done0, result} !== {1'b0, 1'b0, 16'h0084}) begin
            n_err++; $display("FAIL basic_after: got busy=%0d done0=%0d res=%h required 0 0 0084", busy, done0, result); end
    endtask

    task automatic test_arbitration();
        int kd[4]; bit wd[4]; logic [15:0] rd[4]; int nd = 0;
        int exp_k[4]; bit exp_w[4]; logic [15:0] exp_r[4];
        exp_k = '{10, 21, 32, 43}; exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_r = '{16'd15, 16'd63, 16'd15, 16'd63};
        for (int i = 0; i < 4; i++) begin kd[i] = -1; wd[i] = 1'b0; rd[i] = 16'hxxxx; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 1; k <= 60 && nd < 4; k++) begin
            @(negedge clk);
            if (done0 || done1) begin kd[nd] = k; wd[nd] = done1; rd[nd] = result; nd++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wd[i] !== exp_w[i]) begin
                n_err++; $display("FAIL arb_winner[%0d]: got %0d required %0d", i, wd[i], exp_w[i]); end
            n_cmp++; if (kd[i] !== exp_k[i]) begin
                n_err++; $display("FAIL arb_time[%0d]: got %0d required %0d", i, kd[i], exp_k[i]); end
            n_cmp++; if (rd[i] !== exp_r[i]) begin
                n_err++; $display("FAIL arb_result[%0d]: got %0d required %0d", i, rd[i], exp_r[i]); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa[3]; logic [7:0] ob[3]; logic [15:0] op[3]; int exp_k[3];
        int kd[3]; int nd = 0; int na = 0; int n_bad = 0; int n_d0 = 0;
        logic [15:0] held = 16'h0;
        oa = '{8'd20, 8'd3, 8'd255}; ob = '{8'd13, 8'd4, 8'd255};
        op = '{16'd260, 16'd12, 16'hFE01}; exp_k = '{10, 21, 32};
        for (int i = 0; i < 3; i++) kd[i] = -1;
        a1 = oa[0]; b1 = ob[0]; req1 = 1'b1;
        for (int k = 1; k <= 45 && nd < 3; k++) begin
            @(negedge clk);
            if (done0) n_d0++;
            if (ack1) begin
                na++;
                if (na < 3) begin a1 = oa[na]; b1 = ob[na]; end
            end
            if (done1) begin
                kd[nd] = k;
                n_cmp++; if (result !== op[nd]) begin
                    n_err++; $display("FAIL b2b_result[%0d]: got %h required %h", nd, result, op[nd]); end
                held = op[nd]; nd++;
            end else if (nd > 0 && result !== held) begin
                n_bad++;
            end
        end
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (kd[i] !== exp_k[i]) begin
                n_err++; $display("FAIL b2b_time[%0d]: got %0d required %0d", i, kd[i], exp_k[i]); end
        end
        n_cmp++; if (n_bad !== 0) begin
            n_err++; $display("FAIL b2b_hold: got %0d changed cycles required 0", n_bad); end
        n_cmp++; if (n_d0 !== 0) begin
            n_err++; $display("FAIL b2b_done0: got %0d pulses required 0", n_d0); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k_ack, k_done, n_load, n_busy; bit aw, dw; logic [15:0] res;
        int n_act = 0;
        a0 = 8'd6; b0 = 8'd7; req0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
        end
        req0 = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre_busy: got %0d required 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({ack0, ack1, done0, done1, busy, mul_load} !== 6'b0) begin
            n_err++; $display("FAIL rstmid_ctrl: got %b required 000000", {ack0, ack1, done0, done1, busy, mul_load}); end
        n_cmp++; if ({result, mul_a, mul_b} !== 32'h0) begin
            n_err++; $display("FAIL rstmid_data: got %h required 0", {result, mul_a, mul_b}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done0 || done1 || busy) n_act++;
        end
        n_cmp++; if (n_act !== 0) begin
            n_err++; $display("FAIL rstmid_quiet: got %0d active cycles required 0", n_act); end
        run_op(1'b0, 8'd9, 8'd10, k_ack, aw, k_done, dw, res, n_load, n_busy);
        n_cmp++; if (k_ack !== 1 || k_done !== 10 || dw !== 1'b0) begin
            n_err++; $display("FAIL rstmid_fresh: got ack=%0d done=%0d who=%0d required 1 10 0", k_ack, k_done, dw); end
        n_cmp++; if (res !== 16'd90) begin
            n_err++; $display("FAIL rstmid_result: got %0d required 90", res); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withdraw();
        int n_a0 = 0, n_d0 = 0, k_d1 = -1;
        logic [15:0] res = 16'hxxxx;
        a1 = 8'd15; b1 = 8'd17; req1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (ack1) req1 = 1'b0;
            if (ack0) n_a0++;
            if (done0) n_d0++;
            if (done1 && k_d1 < 0) begin k_d1 = k; res = result; end
            if (k == 3) begin a0 = 8'd2; b0 = 8'd2; req0 = 1'b1; end
            if (k == 5) req0 = 1'b0;
        end
        req1 = 1'b0; req0 = 1'b0;
        n_cmp++; if (n_a0 !== 0 || n_d0 !== 0) begin
            n_err++; $display("FAIL withdraw_req0: got ack0=%0d done0=%0d required 0 0", n_a0, n_d0); end
        n_cmp++; if (k_d1 !== 10) begin
            n_err++; $display("FAIL withdraw_done1: got %0d required 10", k_d1); end
        n_cmp++; if (res !== 16'd255) begin
            n_err++; $display("FAIL withdraw_result: got %0d required 255", res); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero();
        int k_ack, k_done, n_load, n_busy; bit aw, dw; logic [15:0] res;
        int exp_done, exp_load; logic [7:0] exp_a, exp_b;
`ifdef MUL_ZERO_BYPASS_EN
        exp_done = 1; exp_load = 0; exp_a = 8'd15; exp_b = 8'd17;
`else
        exp_done = 10; exp_load = 1; exp_a = 8'd0; exp_b = 8'd200;
`endif
        run_op(1'b0, 8'd0, 8'd200, k_ack, aw, k_done, dw, res, n_load, n_busy);
        n_cmp++; if (k_ack !== 1 || aw !== 1'b0) begin
            n_err++; $display("FAIL zero_ack: got k=%0d who=%0d required k=1 who=0", k_ack, aw); end
        n_cmp++; if (k_done !== exp_done || dw !== 1'b0) begin
            n_err++; $display("FAIL zero_done: got k=%0d who=%0d required k=%0d who=0", k_done, dw, exp_done); end
        n_cmp++; if (res !== 16'd0) begin
            n_err++; $display("FAIL zero_result: got %h required 0000", res); end
        n_cmp++; if (n_load !== exp_load) begin
            n_err++; $display("FAIL zero_load: got %0d required %0d", n_load, exp_load); end
        n_cmp++; if (mul_a !== exp_a || mul_b !== exp_b) begin
            n_err++; $display("FAIL zero_operands: got %0d,%0d required %0d,%0d", mul_a, mul_b, exp_a, exp_b); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        @(negedge clk);
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_withdraw();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
